// File: rtl/apb2axi_pkg.sv
// Shared types for the ACLK-side completion builder.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package apb2axi_pkg;

  localparam int TAG_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             is_write;
    logic             error;
    logic [1:0]       resp;
    logic [7:0]       num_beats;   // AXI LEN encoding: beats-1
  } completion_entry_t;

  localparam int COMPLETION_W = $bits(completion_entry_t);

  typedef struct packed {
    logic              vld;
    completion_entry_t entry;
  } cpl_slot_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

  // The AXI resp encoding is ordered by severity, so a numeric max is the worst.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apb2axi_cpl_arb.sv
// Two-slot round-robin arbiter between the write and read completion slots.
// Latency: combinational grant; rr pointer updates on the push edge.
// Backpressure: a slot drains only when i_push_ready is high while it is granted.
// Ports: i_clk/i_rst_n; i_wr_vld/i_rd_vld slot occupancy; i_push_ready from the CQ;
//        o_push_valid toward the CQ; o_grant_rd selects the read slot;
//        o_wr_drain/o_rd_drain pulse when the corresponding slot is pushed.
module apb2axi_cpl_arb
  import apb2axi_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_wr_vld,
  input  logic i_rd_vld,
  input  logic i_push_ready,
  output logic o_push_valid,
  output logic o_grant_rd,
  output logic o_wr_drain,
  output logic o_rd_drain
);

  grant_e r_rr;
  logic   w_fire;

  assign o_push_valid = i_wr_vld | i_rd_vld;
  // A lone valid slot always wins; the pointer only decides real contention.
  assign o_grant_rd   = i_rd_vld & (!i_wr_vld | (r_rr == GNT_RD));
  assign w_fire       = o_push_valid & i_push_ready;
  assign o_wr_drain   = w_fire & !o_grant_rd;
  assign o_rd_drain   = w_fire & o_grant_rd;

  // The pointer moves away from the winner of a contested push, so
  // successive collisions alternate their winner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr <= GNT_WR;
    end else if (w_fire & i_wr_vld & i_rd_vld) begin
      r_rr <= o_grant_rd ? GNT_WR : GNT_RD;
    end
  end

endmodule

// File: rtl/apb2axi_completion_builder.sv
// Builds one completion entry per finished AXI write (B) or read (last R) and pushes it to the CQ.
// Latency: B or last-R handshake at cycle N gives cq_push_valid at N+1 when the CQ is not blocked.
// Backpressure: bready/rready drop while their slot is full and cannot drain; nothing is dropped.
// Ports: aclk/aresetn; aw_issue_* records AWLEN per tag; bvalid/bready/bid/bresp write responses;
//        rvalid/rready/rid/rresp/rlast read beats (monitored); cq_push_valid/data/ready CQ write side.
module apb2axi_completion_builder
  import apb2axi_pkg::*;
#(
  parameter int TAG_W_P    = TAG_W,
  parameter int CPL_W_P    = COMPLETION_W,
  parameter int NUM_TAGS_P = 2**TAG_W_P
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               aw_issue_valid,
  input  logic [TAG_W_P-1:0] aw_issue_tag,
  input  logic [7:0]         aw_issue_len,
  input  logic               bvalid,
  output logic               bready,
  input  logic [TAG_W_P-1:0] bid,
  input  logic [1:0]         bresp,
  input  logic               rvalid,
  output logic               rready,
  input  logic [TAG_W_P-1:0] rid,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  output logic               cq_push_valid,
  output logic [CPL_W_P-1:0] cq_push_data,
  input  logic               cq_push_ready
);

  logic [7:0] r_wlen  [NUM_TAGS_P];
  logic [7:0] r_cnt   [NUM_TAGS_P];
  logic [1:0] r_worst [NUM_TAGS_P];

  cpl_slot_t r_wr_slot;
  cpl_slot_t r_rd_slot;
  // Holds bready/rready low through reset and the first cycle after release.
  logic      r_run;

  logic              w_push_valid;
  logic              w_grant_rd;
  logic              w_wr_drain;
  logic              w_rd_drain;
  logic              w_b_fire;
  logic              w_r_fire;
  logic [1:0]        w_rd_resp;
  completion_entry_t w_b_entry;
  completion_entry_t w_r_entry;
  completion_entry_t w_push_entry;

  apb2axi_cpl_arb u_arb (
    .i_clk        (aclk),
    .i_rst_n      (aresetn),
    .i_wr_vld     (r_wr_slot.vld),
    .i_rd_vld     (r_rd_slot.vld),
    .i_push_ready (cq_push_ready),
    .o_push_valid (w_push_valid),
    .o_grant_rd   (w_grant_rd),
    .o_wr_drain   (w_wr_drain),
    .o_rd_drain   (w_rd_drain)
  );

  // A slot may be refilled in the same cycle it drains.
  assign bready   = r_run & (!r_wr_slot.vld | w_wr_drain);
  assign rready   = r_run & (!r_rd_slot.vld | w_rd_drain);
  assign w_b_fire = bvalid & bready;
  assign w_r_fire = rvalid & rready;

  assign w_rd_resp = resp_max(r_worst[rid], rresp);

  always_comb begin
    w_b_entry           = '0;
    w_b_entry.tag       = TAG_W'(bid);
    w_b_entry.is_write  = 1'b1;
    w_b_entry.resp      = bresp;
    w_b_entry.error     = bresp[1];
    w_b_entry.num_beats = r_wlen[bid];   // pre-edge value even if AW rewrites this tag now

    w_r_entry           = '0;
    w_r_entry.tag       = TAG_W'(rid);
    w_r_entry.is_write  = 1'b0;
    w_r_entry.resp      = w_rd_resp;
    w_r_entry.error     = w_rd_resp[1];
    w_r_entry.num_beats = r_cnt[rid];    // beats seen before rlast == beats-1
  end

  assign w_push_entry  = w_grant_rd ? r_rd_slot.entry : r_wr_slot.entry;
  assign cq_push_valid = w_push_valid;
  assign cq_push_data  = CPL_W_P'(w_push_entry);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_TAGS_P; i++) begin
        r_wlen[i]  <= '0;
        r_cnt[i]   <= '0;
        r_worst[i] <= RESP_OKAY;
      end
    end else begin
      if (aw_issue_valid) begin
        r_wlen[aw_issue_tag] <= aw_issue_len;
      end
      if (w_r_fire) begin
        if (rlast) begin
          r_cnt[rid]   <= '0;
          r_worst[rid] <= RESP_OKAY;
        end else begin
          r_cnt[rid]   <= r_cnt[rid] + 8'd1;
          r_worst[rid] <= w_rd_resp;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_run     <= 1'b0;
      r_wr_slot <= '0;
      r_rd_slot <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_b_fire) begin
        r_wr_slot.vld   <= 1'b1;
        r_wr_slot.entry <= w_b_entry;
      end else if (w_wr_drain) begin
        r_wr_slot <= '0;
      end
      if (w_r_fire & rlast) begin
        r_rd_slot.vld   <= 1'b1;
        r_rd_slot.entry <= w_r_entry;
      end else if (w_rd_drain) begin
        r_rd_slot <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb2axi_completion_builder.sv
module tb_apb2axi_completion_builder;
  import apb2axi_pkg::*;

  localparam int TW = TAG_W;
  localparam int CW = COMPLETION_W;
  localparam int NT = 2**TW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          aw_issue_valid = 1'b0;
  logic [TW-1:0] aw_issue_tag = '0;
  logic [7:0]    aw_issue_len = '0;
  logic          bvalid = 1'b0;
  logic          bready;
  logic [TW-1:0] bid = '0;
  logic [1:0]    bresp = '0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [TW-1:0] rid = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0;
  logic          cq_push_valid;
  logic [CW-1:0] cq_push_data;
  logic          cq_push_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [CW-1:0]     got_q [$];
  int                wlen_m [NT];
  int                pend [NT][$];
  completion_entry_t exp_w [$];
  completion_entry_t exp_r [$];

  apb2axi_completion_builder dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .aw_issue_valid (aw_issue_valid),
    .aw_issue_tag   (aw_issue_tag),
    .aw_issue_len   (aw_issue_len),
    .bvalid         (bvalid),
    .bready         (bready),
    .bid            (bid),
    .bresp          (bresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .rid            (rid),
    .rresp          (rresp),
    .rlast          (rlast),
    .cq_push_valid  (cq_push_valid),
    .cq_push_data   (cq_push_data),
    .cq_push_ready  (cq_push_ready)
  );

  always #5 aclk = ~aclk;

  // Record every entry that will be accepted at the coming rising edge.
  always @(negedge aclk) begin
    if (aresetn && cq_push_valid && cq_push_ready) got_q.push_back(cq_push_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic completion_entry_t mk(input int tag, input int w, input int resp, input int nb);
    completion_entry_t e;
    e.tag       = TW'(tag);
    e.is_write  = (w != 0);
    e.resp      = 2'(resp);
    e.error     = (resp >= 2);   // SLVERR or DECERR
    e.num_beats = 8'(nb);
    return e;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue_aw(input int t, input int l);
    aw_issue_valid = 1'b1;
    aw_issue_tag   = TW'(t);
    aw_issue_len   = 8'(l);
    step();
    aw_issue_valid = 1'b0;
  endtask

  task automatic send_b(input int t, input int r);
    bit ok = 0;
    bvalid = 1'b1;
    bid    = TW'(t);
    bresp  = 2'(r);
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (bready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL b_handshake: bready stayed %b, required 1", bready);
    end
    step();
    bvalid = 1'b0;
  endtask

  task automatic send_r(input int t, input int r, input int last);
    bit ok = 0;
    rvalid = 1'b1;
    rid    = TW'(t);
    rresp  = 2'(r);
    rlast  = (last != 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (rready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL r_handshake: rready stayed %b, required 1", rready);
    end
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic get_entry(output completion_entry_t e, output bit ok);
    ok = 0;
    e  = '0;
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() > 0) begin e = got_q.pop_front(); ok = 1; break; end
      @(negedge aclk);
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL cq_timeout: no entry pushed, required one");
    end
    step();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_cmp++;
    if ({bready, rready, cq_push_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl: bready/rready/valid=%b required 000", {bready, rready, cq_push_valid});
    end
    n_cmp++;
    if (cq_push_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h required 0", cq_push_data);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    n_cmp++;
    if ({bready, rready} !== 2'b00) begin
      n_err++;
      $display("FAIL post_reset_ready: got %b required 00", {bready, rready});
    end
    step(); step();
  endtask

  task automatic test_write();
    completion_entry_t e;
    bit ok;
    issue_aw(3, 7);
    send_b(3, RESP_OKAY);
    @(negedge aclk);
    n_cmp++;
    if (cq_push_valid !== 1'b1) begin
      n_err++;
      $display("FAIL write_latency: cq_push_valid=%b one cycle after B, required 1", cq_push_valid);
    end
    get_entry(e, ok);
    n_cmp++;
    if (e !== mk(3, 1, 0, 7)) begin
      n_err++;
      $display("FAIL write_entry: got %h required %h", e, mk(3, 1, 0, 7));
    end
    // AW rewrite of the same tag in the same cycle as B: B sees the old length.
    aw_issue_valid = 1'b1; aw_issue_tag = 4'd3; aw_issue_len = 8'd9;
    send_b(3, RESP_SLVERR);
    aw_issue_valid = 1'b0;
    get_entry(e, ok);
    n_cmp++;
    if (e !== mk(3, 1, 2, 7)) begin
      n_err++;
      $display("FAIL write_same_cycle_aw: got %h required %h", e, mk(3, 1, 2, 7));
    end
    send_b(3, RESP_DECERR);
    get_entry(e, ok);
    n_cmp++;
    if (e !== mk(3, 1, 3, 9)) begin
      n_err++;
      $display("FAIL write_new_len: got %h required %h", e, mk(3, 1, 3, 9));
    end
  endtask

  task automatic test_read();
    completion_entry_t e;
    bit ok;
    send_r(5, RESP_OKAY, 0);
    send_r(5, RESP_OKAY, 0);
    send_r(5, RESP_SLVERR, 0);
    send_r(5, RESP_OKAY, 1);
    get_entry(e, ok);
    n_cmp++;
    if (e !== mk(5, 0, 2, 3)) begin
      n_err++;
      $display("FAIL read_entry: got %h required %h", e, mk(5, 0, 2, 3));
    end
    send_r(5, RESP_OKAY, 1);
    get_entry(e, ok);
    n_cmp++;
    if (e !== mk(5, 0, 0, 0)) begin
      n_err++;
      $display("FAIL read_cleared: got %h required %h", e, mk(5, 0, 0, 0));
    end
  endtask

  task automatic test_interleave();
    completion_entry_t e;
    bit ok;
    send_r(1, RESP_OKAY, 0);
    send_r(2, RESP_EXOKAY, 0);
    send_r(1, RESP_OKAY, 1);
    send_r(2, RESP_OKAY, 1);
    get_entry(e, ok);
    n_cmp++;
    if (e !== mk(1, 0, 0, 1)) begin
      n_err++;
      $display("FAIL interleave_tag1: got %h required %h", e, mk(1, 0, 0, 1));
    end
    get_entry(e, ok);
    n_cmp++;
    if (e !== mk(2, 0, 1, 1)) begin
      n_err++;
      $display("FAIL interleave_tag2: got %h required %h", e, mk(2, 0, 1, 1));
    end
  endtask

  task automatic test_simultaneous();
    completion_entry_t e1, e2, w, r;
    bit ok;
    issue_aw(0, 2);
    w = mk(0, 1, 0, 2);
    r = mk(4, 0, 1, 0);
    for (int p = 0; p < 2; p++) begin
      bvalid = 1'b1; bid = 4'd0; bresp = RESP_OKAY;
      rvalid = 1'b1; rid = 4'd4; rresp = RESP_EXOKAY; rlast = 1'b1;
      @(negedge aclk);
      n_cmp++;
      if ({bready, rready} !== 2'b11) begin
        n_err++;
        $display("FAIL sim_ready_pair%0d: got %b required 11", p, {bready, rready});
      end
      step();
      bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      get_entry(e1, ok);
      get_entry(e2, ok);
      n_cmp++;
      if ((p == 0) ? ({e1, e2} !== {w, r}) : ({e1, e2} !== {r, w})) begin
        n_err++;
        $display("FAIL sim_order_pair%0d: got %h,%h required %s first", p, e1, e2, (p == 0) ? "WR" : "RD");
      end
    end
  endtask

  task automatic test_backpressure();
    completion_entry_t e1, e2, ew, er;
    logic [CW-1:0] snap;
    bit ok;
    issue_aw(7, 15);
    cq_push_ready = 1'b0;
    bvalid = 1'b1; bid = 4'd7; bresp = RESP_SLVERR;
    rvalid = 1'b1; rid = 4'd8; rresp = RESP_DECERR; rlast = 1'b1;
    step();
    // Second pair is held while both slots are full.
    bid = 4'd7; rid = 4'd8; rlast = 1'b0;
    @(negedge aclk);
    snap = cq_push_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      n_cmp++;
      if ({bready, rready, cq_push_valid} !== 3'b001 || cq_push_data !== snap) begin
        n_err++;
        $display("FAIL bp_hold_c%0d: rdy/rdy/vld=%b data=%h required 001 data=%h",
                 i, {bready, rready, cq_push_valid}, cq_push_data, snap);
      end
    end
    step();
    bvalid = 1'b0; rvalid = 1'b0;
    cq_push_ready = 1'b1;
    get_entry(e1, ok);
    get_entry(e2, ok);
    if (e1.is_write) begin ew = e1; er = e2; end else begin ew = e2; er = e1; end
    n_cmp++;
    if (ew !== mk(7, 1, 2, 15)) begin
      n_err++;
      $display("FAIL bp_write: got %h required %h", ew, mk(7, 1, 2, 15));
    end
    n_cmp++;
    if (er !== mk(8, 0, 3, 0)) begin
      n_err++;
      $display("FAIL bp_read: got %h required %h", er, mk(8, 0, 3, 0));
    end
  endtask

  task automatic test_long_burst();
    completion_entry_t e;
    bit ok;
    for (int i = 0; i < 256; i++) begin
      send_r(9, (i == 255) ? RESP_EXOKAY : ((i == 100) ? RESP_DECERR : RESP_OKAY), (i == 255));
    end
    get_entry(e, ok);
    n_cmp++;
    if (e !== mk(9, 0, 3, 255)) begin
      n_err++;
      $display("FAIL long_burst: got %h required %h", e, mk(9, 0, 3, 255));
    end
  endtask

  task automatic test_reset_mid_burst();
    completion_entry_t e;
    bit ok;
    send_r(6, RESP_SLVERR, 0);
    send_r(6, RESP_SLVERR, 0);
    rvalid = 1'b1; rid = 4'd6; rresp = RESP_DECERR; rlast = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    n_cmp++;
    if ({bready, rready, cq_push_valid} !== 3'b000 || cq_push_data !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: rdy/rdy/vld=%b data=%h required 000 data=0",
               {bready, rready, cq_push_valid}, cq_push_data);
    end
    step();
    rvalid = 1'b0;
    aresetn = 1'b1;
    step(); step();
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++;
      $display("FAIL mid_reset_no_entry: %0d entries pushed, required 0", got_q.size());
    end
    send_r(6, RESP_OKAY, 1);
    get_entry(e, ok);
    n_cmp++;
    if (e !== mk(6, 0, 0, 0)) begin
      n_err++;
      $display("FAIL mid_reset_fresh: got %h required %h", e, mk(6, 0, 0, 0));
    end
    // Length table was cleared too: tag 3 last recorded len 9 before reset.
    send_b(3, RESP_OKAY);
    get_entry(e, ok);
    n_cmp++;
    if (e !== mk(3, 1, 0, 0)) begin
      n_err++;
      $display("FAIL mid_reset_wlen: got %h required %h", e, mk(3, 1, 0, 0));
    end
  endtask

  task automatic test_random();
    completion_entry_t e;
    int op, t, r, l, m;
    for (int i = 0; i < NT; i++) begin
      wlen_m[i] = 0;
      pend[i].delete();
    end
    for (int k = 0; k < 300; k++) begin
      cq_push_ready = 1'($urandom_range(0, 1));
      step();
      cq_push_ready = 1'b1;
      op = int'($urandom_range(0, 9));
      t  = int'($urandom_range(0, NT - 1));
      r  = int'($urandom_range(0, 3));
      if (op < 2) begin
        l = int'($urandom_range(0, 255));
        issue_aw(t, l);
        wlen_m[t] = l;
      end else if (op < 4) begin
        send_b(t, r);
        exp_w.push_back(mk(t, 1, r, wlen_m[t]));
      end else begin
        l = ($urandom_range(0, 3) == 0) ? 1 : 0;
        send_r(t, r, l);
        pend[t].push_back(r);
        if (l != 0) begin
          m = 0;
          foreach (pend[t][j]) if (pend[t][j] > m) m = pend[t][j];
          exp_r.push_back(mk(t, 0, m, pend[t].size() - 1));
          pend[t].delete();
        end
      end
    end
    repeat (5) step();
    while (got_q.size() > 0) begin
      e = got_q.pop_front();
      n_cmp++;
      if (e.is_write) begin
        if (exp_w.size() == 0) begin
          n_err++;
          $display("FAIL rand_write: unexpected %h, required none", e);
        end else if (e !== exp_w[0]) begin
          n_err++;
          $display("FAIL rand_write: got %h required %h", e, exp_w[0]);
          void'(exp_w.pop_front());
        end else begin
          void'(exp_w.pop_front());
        end
      end else begin
        if (exp_r.size() == 0) begin
          n_err++;
          $display("FAIL rand_read: unexpected %h, required none", e);
        end else if (e !== exp_r[0]) begin
          n_err++;
          $display("FAIL rand_read: got %h required %h", e, exp_r[0]);
          void'(exp_r.pop_front());
        end else begin
          void'(exp_r.pop_front());
        end
      end
    end
    n_cmp++;
    if (exp_w.size() != 0 || exp_r.size() != 0) begin
      n_err++;
      $display("FAIL rand_missing: %0d writes %0d reads undelivered, required 0 0", exp_w.size(), exp_r.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_interleave();
    test_simultaneous();
    test_backpressure();
    test_long_burst();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
